// File: rtl/sign_ext_pipe.sv
// Streaming sign/zero extender with a valid/ready output register.
// Define EXT_SKID_EN to add a skid register and register the in_ready output.
module sign_ext_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int SIZE_W     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [SIZE_W-1:0]     in_size,
   input  logic                  in_signed,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_trunc
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1
`ifdef EXT_SKID_EN
      , TWO = 2'd2
`endif
   } state_t;

   // Returns {trunc, extended word}. The field is parked at the top of the
   // word and shifted back down, arithmetically when sign extension is wanted.
   function automatic logic [DATA_WIDTH:0] extend(
      input logic [DATA_WIDTH-1:0] d,
      input logic [SIZE_W-1:0]     sz,
      input logic                  sg
   );
      int unsigned                   sw;
      int unsigned                   sh;
      logic signed [DATA_WIDTH-1:0]  t;
      logic        [DATA_WIDTH:0]    res;
      sw = 32'd8 << sz;
      if (sw >= DATA_WIDTH) begin
         res = {1'b1, d};
      end else begin
         sh = DATA_WIDTH - sw;
         t  = $signed(d << sh);
         if (sg) t = t >>> sh;
         else    t = $signed($unsigned(t) >> sh);
         res = {1'b0, $unsigned(t)};
      end
      return res;
   endfunction

   state_t                  state, state_nxt;
   logic                    accept, take;
   logic                    load_main, load_skid, skid_to_main;
   logic [DATA_WIDTH-1:0]   ext_p0;
   logic                    trunc_p0;
   logic [DATA_WIDTH-1:0]   main_p1;
   logic                    main_trunc_p1;

   // ---- stage 0: combinational extension on the input side ----
   assign {trunc_p0, ext_p0} = extend(in_data, in_size, in_signed);

   assign accept    = in_valid && in_ready;
   assign out_valid = (state != EMPTY);
   assign take      = out_valid && out_ready;

   always_comb begin
      state_nxt    = state;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (take && accept) begin
               load_main = 1'b1;
            end else if (take) begin
               state_nxt = EMPTY;
`ifdef EXT_SKID_EN
            end else if (accept) begin
               state_nxt = TWO;
               load_skid = 1'b1;
`endif
            end
         end
`ifdef EXT_SKID_EN
         TWO: begin
            if (take) begin
               state_nxt    = ONE;
               skid_to_main = 1'b1;
            end
         end
`endif
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

`ifdef EXT_SKID_EN
   logic [DATA_WIDTH-1:0] skid_p1;
   logic                  skid_trunc_p1;
   logic                  rdy_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_p1       <= '0;
         skid_trunc_p1 <= 1'b0;
      end else if (load_skid) begin
         skid_p1       <= ext_p0;
         skid_trunc_p1 <= trunc_p0;
      end
   end

   // in_ready is the registered "not full" flag, isolated from out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_p1 <= 1'b1;
      else        rdy_p1 <= (state_nxt != TWO);
   end
   assign in_ready = rdy_p1;
`else
   logic [DATA_WIDTH-1:0] skid_p1;
   logic                  skid_trunc_p1;
   assign skid_p1       = '0;
   assign skid_trunc_p1 = 1'b0;
   assign in_ready      = !out_valid || out_ready;
`endif

   // ---- stage 1: output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_p1       <= '0;
         main_trunc_p1 <= 1'b0;
      end else if (load_main) begin
         main_p1       <= ext_p0;
         main_trunc_p1 <= trunc_p0;
      end else if (skid_to_main) begin
         main_p1       <= skid_p1;
         main_trunc_p1 <= skid_trunc_p1;
      end
   end

   assign out_data  = main_p1;
   assign out_trunc = main_trunc_p1;

endmodule

// File: doc/sign_ext_pipe.md
# sign_ext_pipe

Streaming, parametrised successor to the combinational sign extender. Each transaction carries a DATA_WIDTH-bit word, a runtime source-size code and a signed/unsigned flag. The block sign- or zero-extends the selected low field to DATA_WIDTH and delivers the result through a valid/ready output stage. It sits between a load/data-return path and its consumer, and gives one registered cycle of latency at full throughput.

## Interface
- DATA_WIDTH, 32: output and input word width; power of two, 8..64.
- SIZE_W, 2: width of the size code; fixed at 2.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block accepts when in_valid && in_ready.
- in_data  in  DATA_WIDTH  raw word; only the low field selected by in_size is significant.
- in_size  in  SIZE_W  source width code: 0=8, 1=16, 2=32, 3=64 bits.
- in_signed  in  1  1 = sign extend, 0 = zero extend.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- out_data  out  DATA_WIDTH  extended result.
- out_trunc  out  1  set when in_size selected a field of DATA_WIDTH bits or wider; the word then passes through unmodified.

## Operation
- Source width SW = 8 << in_size.
- If SW >= DATA_WIDTH: out_data = in_data and out_trunc = 1.
- Otherwise:
  - bits [SW-1:0] are copied from in_data;
  - bits [DATA_WIDTH-1:SW] = in_signed ? in_data[SW-1] : 0;
  - out_trunc = 0.
- The extension is computed combinationally on the input side. Only the result is stored; in_size and in_signed are not.
- Storage is a main output register plus, when EXT_SKID_EN is defined, one skid register.
- State machine:
  - EMPTY: nothing held.
  - ONE: main register valid.
  - TWO: main and skid registers valid. Exists only with EXT_SKID_EN.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on output take with no accept.
  - ONE stays in ONE on simultaneous take and accept; the main register loads the new result.
  - ONE→TWO on accept without take; the new result goes to the skid register.
  - TWO→ONE on take; the skid register moves to main.
  - No accept is possible in TWO.
- Ordering is strictly FIFO and no transaction is dropped or duplicated.
- in_data, in_size and in_signed are ignored when in_valid=0.
- out_data and out_trunc hold stable while out_valid && !out_ready.

## Timing
- Reset values (asynchronous, while rst_n=0): state EMPTY, out_valid=0, out_data=0, out_trunc=0. in_ready=1 with EXT_SKID_EN; in_ready=1 without it (out_valid=0).
- Latency: a word accepted in cycle N appears on out_valid/out_data in cycle N+1.
- Throughput: one word per cycle while out_ready=1.
- A reset asserted mid-stream discards all held words. No output handshake completes in the reset cycle.
- Release of rst_n is expected to be synchronised externally. The first accept can occur on the first rising edge after release.

## Configuration
- EXT_SKID_EN defined:
  - in_ready is a register output equal to (state != TWO), with no combinational path from out_ready.
  - Capacity is 2 words.
  - A stall in which out_ready drops for k cycles absorbs at most one extra word.
- EXT_SKID_EN undefined:
  - no skid register and no TWO state;
  - in_ready = !out_valid || out_ready, combinationally;
  - capacity is 1 word and full throughput is kept.
- The datapath result and ordering are identical in both builds.

## Test plan
- Reset then stream with out_ready=1 and DATA_WIDTH=32: in_data=0x000000F0, size 0, signed → 0xFFFFFFF0 one cycle later. Same input unsigned → 0x000000F0. Back-to-back words give out_valid high every cycle.
- Size 1 with in_data=0xABCD8001, signed → 0xFFFF8001. Size 2 → 0xABCD8001 with out_trunc=1. Size 3 → same value with out_trunc=1.
- Backpressure with EXT_SKID_EN: hold out_ready=0 and offer 3 words (A, B, C).
  - A and B are accepted; in_ready=0 in the cycle after B.
  - C waits.
  - Releasing out_ready yields A, B, C in order with no gap after the first take.
- Without EXT_SKID_EN, same stimulus: only A is accepted until it is taken. in_ready follows out_ready combinationally in the same cycle.
- Assert rst_n=0 asynchronously while in TWO: out_valid falls immediately without waiting for a clock edge. After release, the next accepted word is the first output, with no stale A/B.
- Randomised valid/ready for 10k words against a reference model: the output sequence matches exactly and out_data is stable whenever it is stalled.
